// File: rtl/cali_err_align_if.sv
// Sample stream bundle for cali_err_align: the incoming code/error pair and
// the delayed, segment-split pair presented to the calibrator.
interface cali_err_align_if #(
    parameter int WX = 16,
    parameter int WE = 12
);
    logic          IN_VLD;
    logic [WX-1:0] IN_X;
    logic [WE-1:0] IN_ERR;
    logic          OUT_VLD;
    logic [2:0]    OUT_SEG;
    logic [WX-1:0] OUT_XF;
    logic [WE-1:0] OUT_ERR;

    // Producer/consumer side (drives samples in, receives aligned pairs)
    modport master (
        output IN_VLD, IN_X, IN_ERR,
        input  OUT_VLD, OUT_SEG, OUT_XF, OUT_ERR
    );

    // Aligner side
    modport slave (
        input  IN_VLD, IN_X, IN_ERR,
        output OUT_VLD, OUT_SEG, OUT_XF, OUT_ERR
    );
endinterface

// File: rtl/cali_err_align.sv
// cali_err_align: pairs each phase-error sample with the code issued DLY
// accepted samples earlier, blanks outliers, and splits the delayed code
// into a segment index and an in-segment residual for the calibrator.
module cali_err_align #(
    parameter int WX   = 16,
    parameter int WE   = 12,
    parameter int DMAX = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    cali_err_align_if.slave         bus,
    input  logic [$clog2(DMAX)-1:0] DLY,
    input  logic [1:0]              PSEGS,
    input  logic [WE-1:0]           ERR_TH,
    output logic [15:0]             BLANK_CNT,
    output logic [1:0]              STATE
);
    localparam int DW = $clog2(DMAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] wp;
    logic [DW-1:0] dly_q;
    logic [DW-1:0] fill_cnt;
    logic [15:0]   blank_cnt;

    logic          out_vld;
    logic [2:0]    out_seg;
    logic [WX-1:0] out_xf;
    logic [WE-1:0] out_err;

    // Delay line storage; contents need no reset, the fill logic guarantees
    // only written entries are ever paired.
    logic [WX-1:0] mem [DMAX];

    logic          active;
    logic          acc;
    logic          dly_chg;
    logic          proc;
    logic [DW-1:0] rd_addr;
    logic [WX-1:0] xd;
    logic [WE-1:0] mag;
    logic          blank;
    logic [2:0]    seg;
    logic [WX-1:0] xf;

    // Accept/process decode, delayed-code read and segment split
    always_comb begin
        active  = (state != IDLE);
        acc     = active && EN && bus.IN_VLD;
        dly_chg = active && EN && (DLY != dly_q);
        // fill_cnt can exceed dly_q when DLY drops to 0 on a stored sample,
        // so >= rather than == decides when filling is done.
        proc    = acc && !dly_chg && ((state == RUN) || (fill_cnt >= dly_q));

        // Combinational read ahead of the registered write gives
        // read-before-write when addresses coincide.
        rd_addr = wp - dly_q;
        xd      = (dly_q == '0) ? bus.IN_X : mem[rd_addr];

        // Two's-complement magnitude; the most negative value maps to 2^(WE-1)
        if (bus.IN_ERR[WE-1])
            mag = (~bus.IN_ERR) + {{(WE-1){1'b0}}, 1'b1};
        else
            mag = bus.IN_ERR;
        blank = (ERR_TH != '0) && (mag > ERR_TH);

        seg = 3'd0;
        case (PSEGS)
            2'd1:    seg = {2'b00, xd[WX-1]};
            2'd2:    seg = {1'b0, xd[WX-1 -: 2]};
            2'd3:    seg = xd[WX-1 -: 3];
            default: seg = 3'd0;
        endcase
        xf = xd & ({WX{1'b1}} >> PSEGS);
    end

    // Delay line write: every accepted code is stored, including those
    // that only refill the line.
    always_ff @(posedge CLK) begin
        if (acc)
            mem[wp] <= bus.IN_X;
    end

    // Control FSM, write pointer, blank counter and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            wp        <= '0;
            dly_q     <= '0;
            fill_cnt  <= '0;
            blank_cnt <= '0;
            out_vld   <= 1'b0;
            out_seg   <= '0;
            out_xf    <= '0;
            out_err   <= '0;
        end else begin
            out_vld <= 1'b0;
            if (acc)
                wp <= wp + 1'b1;

            case (state)
                IDLE: begin
                    if (EN) begin
                        state    <= FILL;
                        fill_cnt <= '0;
                        dly_q    <= DLY;
                    end
                end
                FILL, RUN: begin
                    if (!EN) begin
                        state <= IDLE;
                    end else if (dly_chg) begin
                        // Refill against the new latency; a sample arriving
                        // now counts as the first stored one.
                        dly_q    <= DLY;
                        fill_cnt <= {{(DW-1){1'b0}}, acc};
                        state    <= FILL;
                    end else if (acc) begin
                        if (proc)
                            state <= RUN;
                        else
                            fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (proc) begin
                if (blank) begin
                    if (blank_cnt != 16'hFFFF)
                        blank_cnt <= blank_cnt + 16'd1;
                end else begin
                    out_vld <= 1'b1;
                    out_seg <= seg;
                    out_xf  <= xf;
                    out_err <= bus.IN_ERR;
                end
            end
        end
    end

    assign bus.OUT_VLD = out_vld;
    assign bus.OUT_SEG = out_seg;
    assign bus.OUT_XF  = out_xf;
    assign bus.OUT_ERR = out_err;
    assign BLANK_CNT   = blank_cnt;
    assign STATE       = state;

endmodule

// File: tb/tb_cali_err_align.sv
// Directed bench for cali_err_align: table of per-cycle vectors for the
// pairing/split/blanking paths, plus hand sequences for multi-cycle cases.
module tb_cali_err_align;
    localparam int WX = 16;
    localparam int WE = 12;
    localparam int DMAX = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [3:0]  DLY;
    logic [1:0]  PSEGS;
    logic [11:0] ERR_TH;
    logic [15:0] BLANK_CNT;
    logic [1:0]  STATE;

    int total = 0;
    int bad   = 0;

    cali_err_align_if #(.WX(WX), .WE(WE)) bus ();

    cali_err_align #(.WX(WX), .WE(WE), .DMAX(DMAX)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .bus       (bus.slave),
        .DLY       (DLY),
        .PSEGS     (PSEGS),
        .ERR_TH    (ERR_TH),
        .BLANK_CNT (BLANK_CNT),
        .STATE     (STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic        vld;
        logic [15:0] x;
        logic [11:0] err;
        logic [3:0]  dly;
        logic [1:0]  ps;
        logic [11:0] th;
        logic        e_vld;
        logic [2:0]  e_seg;
        logic [15:0] e_xf;
        logic [11:0] e_err;
        logic [1:0]  e_st;
        logic [15:0] e_blank;
        logic        chk_d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic en, logic vld, logic [15:0] x, logic [11:0] err,
                                logic [3:0] dly, logic [1:0] ps, logic [11:0] th,
                                logic e_vld, logic [2:0] e_seg, logic [15:0] e_xf,
                                logic [11:0] e_err, logic [1:0] e_st,
                                logic [15:0] e_blank, logic chk_d);
        vec_t v;
        v.en = en; v.vld = vld; v.x = x; v.err = err; v.dly = dly; v.ps = ps; v.th = th;
        v.e_vld = e_vld; v.e_seg = e_seg; v.e_xf = e_xf; v.e_err = e_err;
        v.e_st = e_st; v.e_blank = e_blank; v.chk_d = chk_d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are read there too
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc(input logic en, input logic vld, input logic [15:0] x, input logic [11:0] err);
        EN = en; bus.IN_VLD = vld; bus.IN_X = x; bus.IN_ERR = err;
        step();
    endtask

    int strobes;

    initial begin
        RST = 1'b1; EN = 1'b0; DLY = '0; PSEGS = '0; ERR_TH = '0;
        bus.IN_VLD = 1'b0; bus.IN_X = '0; bus.IN_ERR = '0;

        // Reset held three cycles with EN low
        repeat (3) step();
        RST = 1'b0;
        chk("rst_vld",   32'(bus.OUT_VLD), 0);
        chk("rst_seg",   32'(bus.OUT_SEG), 0);
        chk("rst_xf",    32'(bus.OUT_XF), 0);
        chk("rst_err",   32'(bus.OUT_ERR), 0);
        chk("rst_blank", 32'(BLANK_CNT), 0);
        chk("rst_state", 32'(STATE), 0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, 16'h5555, 12'h001);
            chk($sformatf("idle_vld%0d", i), 32'(bus.OUT_VLD), 0);
            chk($sformatf("idle_st%0d", i), 32'(STATE), 0);
        end

        // Delay pairing, DLY=3 PSEGS=3: first row is the ignored IDLE->FILL sample
        tbl.push_back(mk(1,1,16'hAAAA,12'h000, 3,3,12'h000, 0,0,16'h0000,12'h000, 1,0,0));
        tbl.push_back(mk(1,1,16'h0000,12'h000, 3,3,12'h000, 0,0,16'h0000,12'h000, 1,0,0));
        tbl.push_back(mk(1,1,16'h1000,12'h001, 3,3,12'h000, 0,0,16'h0000,12'h000, 1,0,0));
        tbl.push_back(mk(1,1,16'h2000,12'h002, 3,3,12'h000, 0,0,16'h0000,12'h000, 1,0,0));
        tbl.push_back(mk(1,1,16'h3000,12'h003, 3,3,12'h000, 1,0,16'h0000,12'h003, 2,0,1));
        tbl.push_back(mk(1,1,16'h4000,12'h004, 3,3,12'h000, 1,0,16'h1000,12'h004, 2,0,1));
        tbl.push_back(mk(1,1,16'h5000,12'h005, 3,3,12'h000, 1,1,16'h0000,12'h005, 2,0,1));
        tbl.push_back(mk(1,1,16'h6000,12'h006, 3,3,12'h000, 1,1,16'h1000,12'h006, 2,0,1));
        tbl.push_back(mk(1,1,16'h7000,12'h007, 3,3,12'h000, 1,2,16'h0000,12'h007, 2,0,1));
        tbl.push_back(mk(1,0,16'h0000,12'h000, 3,3,12'h000, 0,2,16'h0000,12'h007, 2,0,1));
        // Segment split with DLY=0 (bypass); DLY change without a sample refills
        tbl.push_back(mk(1,0,16'h0000,12'h000, 0,3,12'h000, 0,2,16'h0000,12'h007, 1,0,1));
        tbl.push_back(mk(1,1,16'hE123,12'h005, 0,3,12'h000, 1,7,16'h0123,12'h005, 2,0,1));
        tbl.push_back(mk(1,1,16'hE123,12'h006, 0,1,12'h000, 1,1,16'h6123,12'h006, 2,0,1));
        tbl.push_back(mk(1,1,16'hE123,12'hFFF, 0,0,12'h000, 1,0,16'hE123,12'hFFF, 2,0,1));
        // Blanking thresholds
        tbl.push_back(mk(1,1,16'h1234,12'hF9B, 0,0,12'h064, 0,0,16'hE123,12'hFFF, 2,1,1));
        tbl.push_back(mk(1,1,16'h1234,12'h064, 0,0,12'h064, 1,0,16'h1234,12'h064, 2,1,1));
        tbl.push_back(mk(1,1,16'h1234,12'h800, 0,0,12'h7FF, 0,0,16'h1234,12'h064, 2,2,1));
        tbl.push_back(mk(1,1,16'h1234,12'h801, 0,0,12'h7FF, 1,0,16'h1234,12'h801, 2,2,1));
        tbl.push_back(mk(1,1,16'h1234,12'h800, 0,0,12'h000, 1,0,16'h1234,12'h800, 2,2,1));

        for (int i = 0; i < tbl.size(); i++) begin
            DLY = tbl[i].dly; PSEGS = tbl[i].ps; ERR_TH = tbl[i].th;
            cyc(tbl[i].en, tbl[i].vld, tbl[i].x, tbl[i].err);
            chk($sformatf("t%0d_vld", i),   32'(bus.OUT_VLD), 32'(tbl[i].e_vld));
            chk($sformatf("t%0d_st", i),    32'(STATE), 32'(tbl[i].e_st));
            chk($sformatf("t%0d_blank", i), 32'(BLANK_CNT), 32'(tbl[i].e_blank));
            if (tbl[i].chk_d) begin
                chk($sformatf("t%0d_seg", i), 32'(bus.OUT_SEG), 32'(tbl[i].e_seg));
                chk($sformatf("t%0d_xf", i),  32'(bus.OUT_XF), 32'(tbl[i].e_xf));
                chk($sformatf("t%0d_err", i), 32'(bus.OUT_ERR), 32'(tbl[i].e_err));
            end
        end

        // Blank counter saturation
        ERR_TH = 12'h001;
        strobes = 0;
        for (int i = 0; i < 70000; i++) begin
            cyc(1'b1, 1'b1, 16'h0000, 12'h002);
            if (bus.OUT_VLD) strobes++;
        end
        chk("sat_strobes", 32'(strobes), 0);
        chk("sat_blank", 32'(BLANK_CNT), 32'h0000FFFF);

        // DLY change mid-run
        ERR_TH = '0; PSEGS = 2'd0; DLY = 4'd3;
        cyc(1'b1, 1'b0, 16'h0000, 12'h000);
        chk("dc_fill_st", 32'(STATE), 1);
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b1, 1'b1, 16'(16'h0100 + k), 12'(k));
            chk($sformatf("dc_store%0d", k), 32'(bus.OUT_VLD), 0);
        end
        cyc(1'b1, 1'b1, 16'h0104, 12'h004);
        chk("dc_run_vld", 32'(bus.OUT_VLD), 1);
        chk("dc_run_xf",  32'(bus.OUT_XF), 32'h0101);
        chk("dc_run_st",  32'(STATE), 2);
        DLY = 4'd1;
        cyc(1'b1, 1'b1, 16'h0105, 12'h005);
        chk("dc_chg_vld", 32'(bus.OUT_VLD), 0);
        chk("dc_chg_st",  32'(STATE), 1);
        cyc(1'b1, 1'b1, 16'h0106, 12'h006);
        chk("dc_new_vld", 32'(bus.OUT_VLD), 1);
        chk("dc_new_xf",  32'(bus.OUT_XF), 32'h0105);
        chk("dc_new_st",  32'(STATE), 2);

        // Sparse IN_VLD, one sample every third cycle
        for (int j = 0; j < 3; j++) begin
            cyc(1'b1, 1'b1, 16'(16'h0200 + j), 12'(12'h010 + j));
            chk($sformatf("gap%0d_vld", j), 32'(bus.OUT_VLD), 1);
            chk($sformatf("gap%0d_xf", j),  32'(bus.OUT_XF), (j == 0) ? 32'h0106 : 32'(16'h0200 + j - 1));
            chk($sformatf("gap%0d_err", j), 32'(bus.OUT_ERR), 32'(12'h010 + j));
            for (int g = 0; g < 2; g++) begin
                cyc(1'b1, 1'b0, 16'h0000, 12'h000);
                chk($sformatf("gap%0d_idle%0d", j, g), 32'(bus.OUT_VLD), 0);
            end
        end

        // EN low mid-run, then refill of one sample
        cyc(1'b0, 1'b1, 16'h0300, 12'h000);
        chk("en0_st", 32'(STATE), 0);
        chk("en0_vld", 32'(bus.OUT_VLD), 0);
        cyc(1'b0, 1'b1, 16'h0300, 12'h000);
        chk("en0_vld2", 32'(bus.OUT_VLD), 0);
        cyc(1'b1, 1'b1, 16'h0300, 12'h000);
        chk("en1_st", 32'(STATE), 1);
        chk("en1_vld", 32'(bus.OUT_VLD), 0);
        cyc(1'b1, 1'b1, 16'h0301, 12'h001);
        chk("refill_vld", 32'(bus.OUT_VLD), 0);
        chk("refill_st", 32'(STATE), 1);
        cyc(1'b1, 1'b1, 16'h0302, 12'h002);
        chk("refill_out_vld", 32'(bus.OUT_VLD), 1);
        chk("refill_out_xf",  32'(bus.OUT_XF), 32'h0301);
        cyc(1'b1, 1'b1, 16'h0303, 12'h003);
        chk("last_vld", 32'(bus.OUT_VLD), 1);
        chk("last_xf",  32'(bus.OUT_XF), 32'h0302);
        cyc(1'b0, 1'b0, 16'h0000, 12'h000);
        chk("fall_vld",  32'(bus.OUT_VLD), 0);
        chk("fall_st",   32'(STATE), 0);
        chk("hold_xf",   32'(bus.OUT_XF), 32'h0302);
        chk("hold_err",  32'(bus.OUT_ERR), 32'h003);

        // Full-depth delay across the buffer wrap
        DLY = 4'd15;
        cyc(1'b1, 1'b0, 16'h0000, 12'h000);
        chk("wr_fill_st", 32'(STATE), 1);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 1'b1, 16'(16'h0500 + k), 12'(k));
            chk($sformatf("wr%0d_vld", k), 32'(bus.OUT_VLD), (k >= 15) ? 32'd1 : 32'd0);
            if (k >= 15) begin
                chk($sformatf("wr%0d_xf", k),  32'(bus.OUT_XF), 32'(16'h0500 + k - 15));
                chk($sformatf("wr%0d_err", k), 32'(bus.OUT_ERR), 32'(k));
            end
        end

        // Reset during FILL
        DLY = 4'd3;
        cyc(1'b1, 1'b1, 16'h0600, 12'h001);
        chk("rf_fill_st", 32'(STATE), 1);
        RST = 1'b1;
        cyc(1'b1, 1'b1, 16'h0601, 12'h002);
        RST = 1'b0;
        chk("rf_vld",   32'(bus.OUT_VLD), 0);
        chk("rf_seg",   32'(bus.OUT_SEG), 0);
        chk("rf_xf",    32'(bus.OUT_XF), 0);
        chk("rf_err",   32'(bus.OUT_ERR), 0);
        chk("rf_blank", 32'(BLANK_CNT), 0);
        chk("rf_st",    32'(STATE), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
